// File: rtl/uart_rx_os_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_os_if : serial line into the receiver, byte/status back out |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface uart_rx_os_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  // master: the receiver producing bytes; slave: the line driver / byte sink
  modport master (input rx, output rx_data, rx_valid, frame_err, busy);
  modport slave  (output rx, input rx_data, rx_valid, frame_err, busy);
endinterface
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_os : 8N1 oversampling UART receiver, LSB first              |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module uart_rx_os #(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  wire logic    clk,
  input  wire logic    rst,
  uart_rx_os_if.master bus
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W    = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SC_W-1:0]  SC_HALF  = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [SC_W-1:0]  sc_q, sc_d;
  logic [2:0]       bi_q, bi_d;
  logic [7:0]       shift_q, shift_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             rx_prev_q, rx_prev_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;

  logic tick;
  logic rx_s;

  assign rx_s = sync2_q;
  // Free-running divider: never re-aligned to the start edge.
  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d     = state_q;
    div_d       = tick ? '0 : div_q + DIV_W'(1);
    sc_d        = sc_q;
    bi_d        = bi_q;
    shift_d     = shift_q;
    sync1_d     = bus.rx;
    sync2_d     = sync1_q;
    rx_prev_d   = sync2_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Edge-triggered so a held-low (break) line cannot retrigger.
        if (rx_prev_q && !rx_s) begin
          sc_d    = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (sc_q == SC_HALF) begin
            if (rx_s) begin
              state_d = S_IDLE;
            end else begin
              sc_d    = '0;
              bi_d    = 3'd0;
              state_d = S_DATA;
            end
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (sc_q == SC_LAST) begin
            shift_d[bi_q] = rx_s;
            sc_d          = '0;
            bi_d          = bi_q + 3'd1;
            if (bi_q == 3'd7) begin
              state_d = S_STOP;
            end
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (sc_q == SC_LAST) begin
            // The byte is presented even on a framing error.
            rx_data_d   = shift_q;
            rx_valid_d  = rx_s;
            frame_err_d = !rx_s;
            sc_d        = '0;
            state_d     = S_IDLE;
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      sc_q        <= '0;
      bi_q        <= 3'd0;
      shift_q     <= 8'h00;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      sc_q        <= sc_d;
      bi_q        <= bi_d;
      shift_q     <= shift_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      rx_prev_q   <= rx_prev_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_rx_os : scoreboard bench, default lane (96 clk/bit) and a   |
// | fast lane (8 clk/bit, DIV=1) for the full byte sweep. Rev 1.0       |
// +--------------------------------------------------------------------+
module tb_uart_rx_os;

  localparam int BIT_A = 96;
  localparam int BIT_B = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       good;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_os_if u_if_a ();
  uart_rx_os_if u_if_b ();

  uart_rx_os #(.CLK_FREQ(1000000), .BAUD_RATE(9600), .OVERSAMPLE(16)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (u_if_a.master)
  );

  uart_rx_os #(.CLK_FREQ(1000000), .BAUD_RATE(125000), .OVERSAMPLE(8)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (u_if_b.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  int   cyc = 0;
  logic rst_seen = 1'b1;
  int   vcnt[2]       = '{0, 0};
  int   fcnt[2]       = '{0, 0};
  int   last_v[2]     = '{0, 0};
  int   prev_v[2]     = '{0, 0};
  logic pulse_prev[2] = '{1'b0, 1'b0};
  logic [7:0] data_prev[2] = '{8'h00, 8'h00};

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic mon_lane(input int l);
    logic       v;
    logic       f;
    logic [7:0] d;
    exp_t       e;
    v = (l == 0) ? u_if_a.rx_valid  : u_if_b.rx_valid;
    f = (l == 0) ? u_if_a.frame_err : u_if_b.frame_err;
    d = (l == 0) ? u_if_a.rx_data   : u_if_b.rx_data;
    if (!rst_seen && !(v || f) && (d !== data_prev[l]))
      check_eq("data_hold", {24'h0, d}, {24'h0, data_prev[l]});
    if (v || f) begin
      check_eq("excl", {31'h0, v & f}, 32'h0);
      check_eq("pulse_width", {31'h0, pulse_prev[l]}, 32'h0);
      if (((l == 0) ? q_a.size() : q_b.size()) == 0) begin
        check_eq("unexpected", {30'h0, f, v}, 32'h0);
      end else begin
        if (l == 0) e = q_a.pop_front();
        else        e = q_b.pop_front();
        check_eq((l == 0) ? "data_a" : "data_b", {24'h0, d}, {24'h0, e.data});
        check_eq("valid", {31'h0, v}, {31'h0, e.good});
        check_eq("ferr", {31'h0, f}, {31'h0, !e.good});
      end
      if (v) begin
        prev_v[l] = last_v[l];
        last_v[l] = cyc;
        vcnt[l]++;
      end
      if (f) fcnt[l]++;
    end
    pulse_prev[l] = v | f;
    data_prev[l]  = d;
  endtask

  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) mon_lane(l);
  end

  task automatic set_rx(input int l, input logic v);
    if (l == 0) u_if_a.rx = v;
    else        u_if_b.rx = v;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int l, input logic [7:0] d, input logic stop, input int bitc);
    exp_t e;
    e.data = d;
    e.good = stop;
    if (l == 0) q_a.push_back(e);
    else        q_b.push_back(e);
    set_rx(l, 1'b0);
    hold(bitc);
    for (int i = 0; i < 8; i++) begin
      set_rx(l, d[i]);
      hold(bitc);
    end
    set_rx(l, stop);
    hold(bitc);
  endtask

  initial begin
    int         gap;
    logic [7:0] d7e;
    d7e = 8'h7E;
    u_if_a.rx = 1'b1;
    u_if_b.rx = 1'b1;
    rst = 1'b1;
    hold(3);
    check_eq("rst_data_a",  {24'h0, u_if_a.rx_data}, 32'h0);
    check_eq("rst_valid_a", {31'h0, u_if_a.rx_valid}, 32'h0);
    check_eq("rst_ferr_a",  {31'h0, u_if_a.frame_err}, 32'h0);
    check_eq("rst_busy_a",  {31'h0, u_if_a.busy}, 32'h0);
    check_eq("rst_data_b",  {24'h0, u_if_b.rx_data}, 32'h0);
    check_eq("rst_busy_b",  {31'h0, u_if_b.busy}, 32'h0);
    rst = 1'b0;
    hold(2 * BIT_A);

    // Single byte
    send(0, 8'h55, 1'b1, BIT_A);
    hold(BIT_A);
    check_eq("t55_cnt", vcnt[0], 1);
    check_eq("t55_busy", {31'h0, u_if_a.busy}, 32'h0);

    // Back-to-back frames, one stop bit each
    send(0, 8'hA3, 1'b1, BIT_A);
    send(0, 8'h0F, 1'b1, BIT_A);
    hold(BIT_A);
    check_eq("b2b_cnt", vcnt[0], 3);
    gap = last_v[0] - prev_v[0];
    if (gap < 954 || gap > 966) check_eq("b2b_gap", gap, 960);
    else                         check_eq("b2b_gap_range", {31'h0, gap >= 954 && gap <= 966}, 32'h1);

    // 20-clk glitch on idle line
    set_rx(0, 1'b0);
    hold(20);
    set_rx(0, 1'b1);
    check_eq("glitch_busy_hi", {31'h0, u_if_a.busy}, 32'h1);
    hold(BIT_A - 20);
    check_eq("glitch_busy_lo", {31'h0, u_if_a.busy}, 32'h0);
    check_eq("glitch_pulses", vcnt[0] + fcnt[0], 3);

    // Framing error, then line held low
    send(0, 8'hC4, 1'b0, BIT_A);
    hold(3 * BIT_A);
    check_eq("ferr_cnt", fcnt[0], 1);
    check_eq("ferr_data", {24'h0, u_if_a.rx_data}, 32'hC4);
    set_rx(0, 1'b1);
    hold(2 * BIT_A);
    check_eq("break_cnt", vcnt[0] + fcnt[0], 4);

    // Reset in the middle of data bit 3 of 0x7E
    set_rx(0, 1'b0);
    hold(BIT_A);
    for (int i = 0; i < 3; i++) begin
      set_rx(0, d7e[i]);
      hold(BIT_A);
    end
    set_rx(0, d7e[3]);
    hold(BIT_A / 2);
    check_eq("rst_mid_busy_hi", {31'h0, u_if_a.busy}, 32'h1);
    rst = 1'b1;
    hold(1);
    check_eq("rst_mid_busy_lo", {31'h0, u_if_a.busy}, 32'h0);
    check_eq("rst_mid_data", {24'h0, u_if_a.rx_data}, 32'h0);
    rst = 1'b0;
    set_rx(0, 1'b1);
    hold(2 * BIT_A);
    check_eq("rst_mid_pulses", vcnt[0] + fcnt[0], 4);
    send(0, 8'h81, 1'b1, BIT_A);
    hold(BIT_A);
    check_eq("after_rst_cnt", vcnt[0], 4);
    check_eq("after_rst_data", {24'h0, u_if_a.rx_data}, 32'h81);

    // Full byte sweep on the fast lane
    for (int b = 0; b < 256; b++) begin
      send(1, b[7:0], 1'b1, BIT_B);
      hold(2 * BIT_B);
    end
    hold(2 * BIT_B);
    check_eq("sweep_valid_cnt", vcnt[1], 256);
    check_eq("sweep_ferr_cnt", fcnt[1], 0);

    check_eq("drain_a", q_a.size(), 0);
    check_eq("drain_b", q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- UART receiver, 8N1, LSB first; the receive-side counterpart to the team's UART transmitter on the same serial link.
- Samples the asynchronous `rx` line with a 2-flop synchroniser and an oversampling tick, then validates the start and stop bits.
- Delivers each byte with a one-cycle `rx_valid` strobe.
- Fully synchronous to `clk`; no derived clocks.

Parameters:
- CLK_FREQ, 1000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate in baud.
- OVERSAMPLE, 16, ticks per bit period; must be even and at least 4.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idles high.
- rx_data  out  8  last received byte; held until the next frame completes.
- rx_valid  out  1  one-cycle pulse when a good frame has been received.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On reset:
  - rx_data=0, rx_valid=0, frame_err=0, busy=0.
  - State goes to IDLE; tick and bit counters clear.
  - Both synchroniser flops load 1.
  - Reset asserted mid-frame abandons the frame with no output pulse.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer truncation; minimum 1.
  - `tick` is a one-clk enable every DIV clks.
  - Defaults: DIV=6, so one bit period = 96 clk.
  - The tick counter free-runs and is not re-aligned on the start edge. Alignment error is at most one tick.
- rx_s is rx after two flops, giving 2 clk of latency. rx_prev holds rx_s delayed by one clk and is used for edge detection.
- IDLE:
  - Start is detected on a falling edge only: rx_prev=1 and rx_s=0, evaluated every clk.
  - On detection: tick counter sc=0, go to START.
  - A line held low (break) never re-triggers a start.
- START:
  - On each tick, sc increments.
  - When sc reaches OVERSAMPLE/2-1, sample rx_s.
  - If the sample is 1, it was a glitch: go to IDLE with no pulses.
  - If the sample is 0: sc=0, bit index bi=0, go to DATA.
- DATA:
  - On each tick, sc increments.
  - When sc reaches OVERSAMPLE-1, that tick is mid-bit. Shift rx_s into bit bi of the shift register (LSB first), then sc=0 and bi increments.
  - After bi=7 is captured, go to STOP.
- STOP:
  - At the mid-bit tick (sc=OVERSAMPLE-1), sample rx_s.
  - Sample 1: rx_data is loaded with the shift register and rx_valid pulses on the next clk.
  - Sample 0: rx_data is still loaded, rx_valid stays 0, and frame_err pulses.
  - In both cases go to IDLE.
- rx_data changes only on the clk where rx_valid or frame_err is asserted.
- A new start falling edge is accepted from the first IDLE clk, so back-to-back frames with exactly one stop bit must be received.
- rx_valid and frame_err are never high together, and neither is ever high for more than one clk.

Test Plan:
- Byte 0x55 (all defaults, 96 clk per bit) -> rx_valid pulses once; rx_data=0x55; frame_err=0.
- Frames 0xA3 then 0x0F back-to-back, one stop bit each -> two rx_valid pulses, rx_data 0xA3 then 0x0F. The pulses are 960±6 clk apart.
- A 20-clk low glitch on idle rx -> no rx_valid, no frame_err; busy returns to 0 within one bit period.
- Byte 0xC4 with the stop bit driven 0 -> frame_err pulses once; rx_valid=0; rx_data=0xC4. Holding rx low afterwards produces no further frames.
- rst asserted for 1 clk during data bit 3 of 0x7E -> busy=0 on the next clk, no pulses. A following 0x81 frame is then received correctly.
- Sweep all bytes 0x00..0xFF, each frame followed by 2 idle stop bits -> 256 rx_valid pulses, data matches, zero frame_err.
